// File: rtl/pes_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pes_arb_pkg
// Description : Shared sizes, FSM state encoding and the rotating-priority
//               search function for the weighted round-robin scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package pes_arb_pkg;

  localparam int N_REQ    = 4;
  localparam int WEIGHT_W = 3;
  localparam int PTR_W    = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Returns {found, index}: the first requester at or after ptr (wrapping)
  // with its request bit set. N_REQ is a power of two, so the PTR_W-bit add
  // wraps modulo N_REQ on its own.
  function automatic logic [PTR_W:0] next_winner(
    input logic [N_REQ-1:0] req,
    input logic [PTR_W-1:0] ptr
  );
    logic             found;
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    // Walk from the lowest priority upward so the highest-priority hit wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + PTR_W'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pes_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : pes_rr_pick
// Description : Combinational rotating-priority picker. Given the request
//               vector and a priority pointer, reports whether any requester
//               is pending, its index and its one-hot encoding.
// Revision    : 1.0 - initial release
// ============================================================================
module pes_rr_pick
  import pes_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic             found,
  output logic [PTR_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);

  logic [PTR_W:0] w_result;

  assign w_result = next_winner(req, ptr);
  assign found    = w_result[PTR_W];
  assign idx      = w_result[PTR_W-1:0];

  // Decode the winning index; all-zero when nobody is requesting.
  always_comb begin
    onehot = '0;
    if (found) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pes_wrr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pes_wrr_scheduler
// Description : Weighted round-robin scheduler for four requesters. A grant
//               is held for up to weight+1 cycles (credit down-counter), then
//               handed to the next requester in rotating-pointer order with
//               no idle cycle in between.
//               Optional macro WRR_LOCK_EN adds a 'lock' input that freezes
//               the credit of the current holder for atomic bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module pes_wrr_scheduler
  import pes_arb_pkg::*;
#(
  parameter int N        = N_REQ,
  parameter int WEIGHT_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic [N*WEIGHT_W-1:0] cfg_weight,
`ifdef WRR_LOCK_EN
  input  logic                  lock,
`endif
  output logic [N-1:0]          grant,
  output logic [PTR_W-1:0]      grant_id,
  output logic                  grant_valid,
  output logic [N-1:0]          io_oeb
);

  state_t              r_state, w_state_nxt;
  logic [PTR_W-1:0]    r_ptr, w_ptr_nxt;
  logic [PTR_W-1:0]    r_grant_id, w_grant_id_nxt;
  logic [N-1:0]        r_grant, w_grant_nxt;
  logic [WEIGHT_W-1:0] r_credit, w_credit_nxt;

  logic [PTR_W-1:0]    w_search_ptr;
  logic                w_pick_found;
  logic [PTR_W-1:0]    w_pick_idx;
  logic [N-1:0]        w_pick_onehot;
  logic [WEIGHT_W-1:0] w_pick_weight;
  logic                w_req_g;
  logic                w_credit_hold;
  logic                w_release;

  // In HOLD the search only matters on release, where the new pointer is
  // g+1; searching from g+1 every cycle lets one picker serve both cases.
  assign w_search_ptr = (r_state == ST_HOLD) ? (r_grant_id + PTR_W'(1)) : r_ptr;

  pes_rr_pick u_pick (
    .req    (req),
    .ptr    (w_search_ptr),
    .found  (w_pick_found),
    .idx    (w_pick_idx),
    .onehot (w_pick_onehot)
  );

  assign w_pick_weight = cfg_weight[w_pick_idx*WEIGHT_W +: WEIGHT_W];
  assign w_req_g       = req[r_grant_id];

`ifdef WRR_LOCK_EN
  assign w_credit_hold = lock & w_req_g;
`else
  assign w_credit_hold = 1'b0;
`endif

  assign w_release = !w_req_g || ((r_credit == '0) && !w_credit_hold);

  // Next-state logic: start, hold, hand over or go idle.
  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_grant_id_nxt = r_grant_id;
    w_grant_nxt    = r_grant;
    w_credit_nxt   = r_credit;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_found) begin
          w_state_nxt    = ST_HOLD;
          w_grant_nxt    = w_pick_onehot;
          w_grant_id_nxt = w_pick_idx;
          w_credit_nxt   = w_pick_weight;
        end
      end
      ST_HOLD: begin
        if (w_release) begin
          w_ptr_nxt = r_grant_id + PTR_W'(1);
          if (w_pick_found) begin
            w_grant_nxt    = w_pick_onehot;
            w_grant_id_nxt = w_pick_idx;
            w_credit_nxt   = w_pick_weight;
          end else begin
            w_state_nxt    = ST_IDLE;
            w_grant_nxt    = '0;
            w_grant_id_nxt = '0;
            w_credit_nxt   = '0;
          end
        end else if (!w_credit_hold) begin
          w_credit_nxt = r_credit - WEIGHT_W'(1);
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_grant_nxt    = '0;
        w_grant_id_nxt = '0;
        w_credit_nxt   = '0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_grant_id <= '0;
      r_grant    <= '0;
      r_credit   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_grant    <= w_grant_nxt;
      r_credit   <= w_credit_nxt;
    end
  end

  assign grant       = r_grant;
  assign grant_id    = r_grant_id;
  assign grant_valid = |r_grant;
  assign io_oeb      = '0;

endmodule
`default_nettype wire

// File: tb/tb_pes_wrr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pes_wrr_scheduler
// Description : Self-checking bench for pes_wrr_scheduler. Directed request
//               patterns push hand-computed grants into a queue; a monitor
//               pops one entry per cycle and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pes_wrr_scheduler;

  localparam int C_N  = 4;
  localparam int C_WW = 3;

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] g;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [C_N-1:0]       req;
  logic [C_N*C_WW-1:0]  cfg_weight;
`ifdef WRR_LOCK_EN
  logic                 lock;
`endif
  logic [C_N-1:0]       grant;
  logic [1:0]           grant_id;
  logic                 grant_valid;
  logic [C_N-1:0]       io_oeb;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  exp_t mon_e;

  pes_wrr_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .cfg_weight  (cfg_weight),
`ifdef WRR_LOCK_EN
    .lock        (lock),
`endif
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .io_oeb      (io_oeb)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] id_of(input logic [3:0] g);
    case (g)
      4'b0010: id_of = 2'd1;
      4'b0100: id_of = 2'd2;
      4'b1000: id_of = 2'd3;
      default: id_of = 2'd0;
    endcase
  endfunction

  // Queue the grant expected after the coming rising edge.
  task automatic expect_next(input logic [3:0] eg);
    q.push_back({id_of(eg), eg});
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] eg);
    @(negedge clk);
    req = r;
    expect_next(eg);
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (grant !== 4'b0000 || grant_id !== 2'd0 || grant_valid !== 1'b0 || io_oeb !== 4'b0000) begin
      errors++;
      $display("FAIL %s: grant=%b id=%0d valid=%b oeb=%b, required all zero", name, grant, grant_id, grant_valid, io_oeb);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = '0;
`ifdef WRR_LOCK_EN
    lock = 1'b0;
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: one expected grant per cycle while the queue holds entries.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      checks++;
      if (grant !== mon_e.g || grant_id !== mon_e.id || grant_valid !== (mon_e.g != 4'b0000)) begin
        errors++;
        $display("FAIL grant_seq @%0t: grant=%b id=%0d valid=%b, required grant=%b id=%0d valid=%b",
                 $time, grant, grant_id, grant_valid, mon_e.g, mon_e.id, (mon_e.g != 4'b0000));
      end
    end
  end

  initial begin
    rst        = 1'b1;
    req        = '0;
    cfg_weight = '0;
`ifdef WRR_LOCK_EN
    lock       = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_idle("reset_state");
    rst = 1'b0;

    // Reset mid-grant: weight0=7, reset lands in the third grant cycle.
    cfg_weight = {3'd0, 3'd0, 3'd0, 3'd7};
    step(4'b0001, 4'b0001);
    step(4'b0001, 4'b0001);
    step(4'b0001, 4'b0001);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_idle("async_reset");
    @(negedge clk);
    rst = 1'b0;
    expect_next(4'b0001);
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);

    // Weight limit: w0=2, w1=0 with both requesting.
    do_reset();
    cfg_weight = {3'd0, 3'd0, 3'd0, 3'd2};
    step(4'b0011, 4'b0001);
    step(4'b0011, 4'b0001);
    step(4'b0011, 4'b0001);
    step(4'b0011, 4'b0010);
    step(4'b0011, 4'b0001);
    step(4'b0011, 4'b0001);
    step(4'b0011, 4'b0001);
    step(4'b0011, 4'b0010);
    step(4'b0000, 4'b0000);

    // Early release of requester 2, then ptr=3 shows up with all requesting.
    do_reset();
    cfg_weight = {3'd0, 3'd7, 3'd0, 3'd0};
    step(4'b0100, 4'b0100);
    step(4'b0100, 4'b0100);
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);
    step(4'b1111, 4'b1000);
    step(4'b0000, 4'b0000);

    // Wrap/fairness: all requesting, all weights 0.
    do_reset();
    cfg_weight = '0;
    step(4'b1111, 4'b0001);
    step(4'b1111, 4'b0010);
    step(4'b1111, 4'b0100);
    step(4'b1111, 4'b1000);
    step(4'b1111, 4'b0001);
    step(4'b0000, 4'b0000);

    // Sole requester 3 with weight 1 keeps the grant across reloads.
    do_reset();
    cfg_weight = {3'd1, 3'd0, 3'd0, 3'd0};
    for (int i = 0; i < 6; i++) begin
      step(4'b1000, 4'b1000);
    end
    step(4'b0000, 4'b0000);
    // ptr is 0 after releasing requester 3: requester 1 wins over 2.
    step(4'b0110, 4'b0010);
    step(4'b0110, 4'b0100);
    step(4'b0000, 4'b0000);

`ifdef WRR_LOCK_EN
    // Lock keeps requester 0 past its zero credit.
    do_reset();
    cfg_weight = '0;
    step(4'b0011, 4'b0001);
    lock = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(4'b0011, 4'b0001);
    end
    step(4'b0011, 4'b0010);
    lock = 1'b0;
    step(4'b0000, 4'b0000);
`endif

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d entries left, required 0", q.size());
    end
    check_idle("final_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pes_wrr_scheduler.md
# pes_wrr_scheduler

Weighted round-robin scheduler that shares one downstream resource among four requesters. Each requester has a programmable weight that bounds how many consecutive cycles it may hold the grant. Fairness comes from a rotating priority pointer. It replaces single-cycle rotating grants with held, credit-limited grants, and drives the same caravel user-IO style outputs.

## Interface
- N, 4, number of requesters (fixed at 4 for this tape-out; logic written for N, pointer width $clog2(N))
- WEIGHT_W, 3, width of each per-requester weight field
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- req  input  N  request per requester, level-sensitive
- cfg_weight  input  N*WEIGHT_W  weight of requester i in bits [i*WEIGHT_W +: WEIGHT_W]; sampled only at grant start
- grant  output  N  registered one-hot grant, 0 when idle
- grant_id  output  2  index of granted requester, 0 when idle
- grant_valid  output  1  OR of grant
- io_oeb  output  N  tied 4'b0000 (all outputs enabled)
- lock  input  1  present only with WRR_LOCK_EN; see Configuration

## Operation
- State machine has two states.
  - IDLE: grant=0. Entered from reset, or when a release finds no pending requests.
  - HOLD: exactly one grant bit set.
- Arbitration search: priority order ptr, ptr+1, … wrapping mod N. Winner is the first i with req[i]=1.
- IDLE → HOLD: when req≠0 at a clock edge.
  - grant ← onehot(winner), grant_id ← winner.
  - credit ← cfg_weight[winner] (WEIGHT_W-bit down-counter).
- HOLD, per edge with g = granted index:
  - Release when req[g]=0 or credit=0.
  - Otherwise credit ← credit−1 and grant unchanged.
- Grant length: weight w gives at most w+1 grant cycles. w=0 gives exactly 1 cycle.
- On release (same edge, no bubble):
  - ptr ← (g+1) mod N.
  - Re-search from the new ptr using current req. g is last in order, so it is re-granted only if it is the sole requester.
  - Winner found: stay in HOLD with the new grant and reload credit.
  - No winner: go to IDLE, grant ← 0.
- Pointer is unchanged in IDLE. Requests arriving in IDLE are served starting from ptr.
- Withdrawn requests: a requester dropping req while not granted is simply skipped.
- Credit arithmetic is unsigned. The decrement never wraps below 0 because release happens at 0.

## Timing
- Reset values: grant=0, grant_id=0, grant_valid=0, io_oeb=0, ptr=0, credit=0, state IDLE.
- Reset is asynchronous: asserting rst mid-HOLD clears grant immediately, without waiting for a clock edge.
- Latency: req rising before edge k gives grant visible after edge k (1 cycle). No combinational path from req to grant.
- Handover between requesters is 0 idle cycles. Grant of the old requester and grant of the new one are on consecutive cycles.
- Release latency: req[g] low before edge k means grant[g] is low after edge k.
- Simultaneous requests: resolved purely by ptr order; lowest index wins only when ptr=0.

## Configuration
- Macro: WRR_LOCK_EN.
  - Defined: port lock exists. In HOLD with lock=1 and req[g]=1, credit is not decremented and the grant is never released for credit exhaustion. This is used for atomic bursts. Dropping req[g] still releases. lock is ignored in IDLE.
  - Undefined: no lock port; behaviour exactly as in Operation.

## Structure
- Shared package pes_arb_pkg holds:
  - localparams N_REQ=4, WEIGHT_W=3, PTR_W=2.
  - State encoding ST_IDLE/ST_HOLD.
  - A function next_winner(req, ptr) returning {found, index}.
- One sub-module, pes_rr_pick: combinational rotating-priority picker (req, ptr → found, idx, onehot). It is used for both IDLE arbitration and release re-arbitration.
- The top holds the FSM, ptr, the credit counter and the output registers.

## Test plan
- Reset mid-grant: req=0001, weight0=7, rst pulsed in the 3rd grant cycle → grant=0 asynchronously, ptr=0; after release of rst, grant=0001 one cycle later.
- Weight limit: req=0011 held, weights {w0=2, w1=0} → grant sequence 0001,0001,0001,0010,0001,0001,0001,0010… with no idle cycles.
- Early release: req=0100 held 2 cycles then dropped, weight2=7 → grant 0100 for 2 cycles, then 0 (IDLE), ptr=3.
- Wrap/fairness: all req=1111, all weights 0, ptr=0 → grant 0001,0010,0100,1000,0001…; grant_id 0,1,2,3,0.
- Sole requester: req=1000 only, weight3=1 → grant 1000 continuously; credit reloads every 2 cycles, ptr=0 after each release.
- WRR_LOCK_EN: req=0011, weight0=0, lock=1 for 5 cycles → grant 0001 for 5+ cycles; lock low → release next edge to 0010.
